// File: rtl/sram_rd_pkg.sv
// ============================================================================
// Module  : sram_rd_pkg
// Brief   : Shared constants and FSM state type for the SRAM burst reader.
// Revision: 1.0
// ============================================================================
`default_nettype none

package sram_rd_pkg;

    localparam int SRAM_DW    = 32;
    localparam int SRAM_AW    = 11;
    localparam int SRAM_DEPTH = 2048;
    localparam int SRAM_LW    = 12;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } rd_state_t;

endpackage

`default_nettype wire

// File: rtl/sram_rd_buf.sv
// ============================================================================
// Module  : sram_rd_buf
// Brief   : 2-entry FIFO holding SRAM words captured for the output stream.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sram_rd_buf
    import sram_rd_pkg::*;
#(
    parameter int DW = SRAM_DW
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          push_i,
    input  logic [DW-1:0] push_data_i,
    input  logic          pop_i,
    output logic [1:0]    count_o,
    output logic [DW-1:0] head_o
);

    logic [DW-1:0] mem_q [2];
    logic          wr_ptr_q;
    logic          rd_ptr_q;
    logic [1:0]    count_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 2; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop_i) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + {1'b0, push_i} - {1'b0, pop_i};
        end
    end

    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

endmodule

`default_nettype wire

// File: rtl/sram_burst_reader.sv
// ============================================================================
// Module  : sram_burst_reader
// Brief   : Streams a LEN-word burst from a 1-cycle-latency SRAM over
//           valid/ready. Option SRAM_RD_CHKSUM_EN adds an XOR checksum port.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sram_burst_reader
    import sram_rd_pkg::*;
#(
    parameter int DW = SRAM_DW,
    parameter int AW = SRAM_AW,
    parameter int LW = SRAM_LW
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic [AW-1:0] base,
    input  logic [LW-1:0] len,
    output logic          busy,
    output logic          done,
    output logic          sram_cen,
    output logic          sram_wen,
    output logic [AW-1:0] sram_a,
    input  logic [DW-1:0] sram_q,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready
`ifdef SRAM_RD_CHKSUM_EN
    ,
    output logic [DW-1:0] chksum
`endif
);

    rd_state_t     state_q, state_d;
    logic [AW-1:0] base_q, base_d;
    logic [LW-1:0] len_q, len_d;
    logic [LW-1:0] issued_q, issued_d;
    logic [LW-1:0] delivered_q, delivered_d;
    logic          inflight_q;
    logic          w_issue;
    logic          w_pop;
    logic [1:0]    w_buf_count;
    logic [2:0]    w_occupancy;
`ifdef SRAM_RD_CHKSUM_EN
    logic [DW-1:0] chksum_q, chksum_d;
`endif

    assign w_pop       = out_valid & out_ready;
    assign w_occupancy = {1'b0, w_buf_count} + {2'b00, inflight_q};

    // A word popped this cycle frees its slot before the new read lands,
    // which is what lets the pipeline sustain one word per clock.
    assign w_issue = (state_q == RUN) && (issued_q < len_q) &&
                     (w_occupancy < (3'd2 + {2'b00, w_pop}));

    assign sram_cen = ~w_issue;
    assign sram_wen = 1'b1;
    assign sram_a   = base_q + issued_q[AW-1:0];
    assign busy     = (state_q == RUN);
    assign done     = (state_q == DONE);
    assign out_valid = (w_buf_count != 2'd0);

    sram_rd_buf #(
        .DW (DW)
    ) u_buf (
        .clk         (clk),
        .reset_n     (reset_n),
        .push_i      (inflight_q),
        .push_data_i (sram_q),
        .pop_i       (w_pop),
        .count_o     (w_buf_count),
        .head_o      (out_data)
    );

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        len_d       = len_q;
        issued_d    = issued_q;
        delivered_d = delivered_q;
`ifdef SRAM_RD_CHKSUM_EN
        chksum_d    = chksum_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    base_d      = base;
                    len_d       = len;
                    issued_d    = '0;
                    delivered_d = '0;
`ifdef SRAM_RD_CHKSUM_EN
                    chksum_d    = '0;
`endif
                    state_d     = (len == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (w_issue) begin
                    issued_d = issued_q + LW'(1);
                end
                if (w_pop) begin
                    delivered_d = delivered_q + LW'(1);
`ifdef SRAM_RD_CHKSUM_EN
                    chksum_d    = chksum_q ^ out_data;
`endif
                    if (delivered_q + LW'(1) == len_q) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            base_q      <= '0;
            len_q       <= '0;
            issued_q    <= '0;
            delivered_q <= '0;
            inflight_q  <= 1'b0;
`ifdef SRAM_RD_CHKSUM_EN
            chksum_q    <= '0;
`endif
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            len_q       <= len_d;
            issued_q    <= issued_d;
            delivered_q <= delivered_d;
            inflight_q  <= w_issue;
`ifdef SRAM_RD_CHKSUM_EN
            chksum_q    <= chksum_d;
`endif
        end
    end

`ifdef SRAM_RD_CHKSUM_EN
    assign chksum = chksum_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sram_burst_reader.sv
// ============================================================================
// Module  : tb_sram_burst_reader
// Brief   : Self-checking bench for sram_burst_reader against a queue model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_sram_burst_reader;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [10:0] base = '0;
    logic [11:0] len = '0;
    logic        busy, done, sram_cen, sram_wen, out_valid;
    logic [10:0] sram_a;
    logic [31:0] sram_q = '0;
    logic [31:0] out_data;
    logic        out_ready = 1'b0;
`ifdef SRAM_RD_CHKSUM_EN
    logic [31:0] chksum;
`endif

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [0:2047];
    logic [31:0] exp_q [$];
    logic [10:0] exp_a [$];
    logic [31:0] exp_x;
    logic [31:0] obs_q [$];
    logic [10:0] addr_q [$];
    int          hs_cyc_q [$];
    int          done_cyc;
    int          stable_err;
    int          busy_err;
    logic        post_done;
    logic        post_busy;
    logic [31:0] chk_at_done;

    sram_burst_reader u_dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .base      (base),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .sram_cen  (sram_cen),
        .sram_wen  (sram_wen),
        .sram_a    (sram_a),
        .sram_q    (sram_q),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef SRAM_RD_CHKSUM_EN
        ,
        .chksum    (chksum)
`endif
    );

    always #5 clk = ~clk;

    // SRAM macro model: 1-cycle read latency
    always @(posedge clk) begin
        if (!sram_cen) sram_q <= mem[sram_a];
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    // Expected words/addresses straight from the address-space arithmetic.
    task automatic build_exp(input logic [10:0] b, input int l);
        exp_q.delete();
        exp_a.delete();
        exp_x = '0;
        for (int i = 0; i < l; i++) begin
            int a;
            a = (int'(b) + i) % 2048;
            exp_a.push_back(11'(a));
            exp_q.push_back(mem[a]);
            exp_x = exp_x ^ mem[a];
        end
    endtask

    // rmode: 0 = always ready, 1 = ready pattern 1,0,0, 2 = random ready
    task automatic run_burst(input logic [10:0] b, input logic [11:0] l,
                             input int rmode, input int budget);
        logic        prev_stall;
        logic [31:0] prev_data;
        obs_q.delete();
        addr_q.delete();
        hs_cyc_q.delete();
        done_cyc    = -1;
        stable_err  = 0;
        busy_err    = 0;
        post_done   = 1'bx;
        post_busy   = 1'bx;
        chk_at_done = '0;
        prev_stall  = 1'b0;
        prev_data   = '0;
        @(posedge clk); #1;
        start = 1'b1; base = b; len = l;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c < budget; c++) begin
            case (rmode)
                0:       out_ready = 1'b1;
                1:       out_ready = (c % 3 == 0);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            #1;
            if (!sram_cen) addr_q.push_back(sram_a);
            if (prev_stall && out_valid && out_data !== prev_data) stable_err++;
            if (out_valid && out_ready) begin
                obs_q.push_back(out_data);
                hs_cyc_q.push_back(c);
            end
            if (done === 1'b1) begin
                done_cyc = c;
`ifdef SRAM_RD_CHKSUM_EN
                chk_at_done = chksum;
`endif
                break;
            end
            if (busy !== 1'b1) busy_err++;
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            @(posedge clk); #1;
        end
        if (done_cyc >= 0) begin
            @(posedge clk); #2;
            post_done = done;
            post_busy = busy;
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, sram_cen, out_valid} !== 4'b0010) begin
            errors++;
            $display("FAIL reset_ctrl: busy/done/cen/valid=%b required 0010", {busy, done, sram_cen, out_valid});
        end
        checks++;
        if (sram_a !== 11'h000 || out_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_data: sram_a=%h out_data=%h required 000/00000000", sram_a, out_data);
        end
        reset_n = 1'b1;
    endtask

    task automatic test_basic;
        for (int a = 0; a < 2048; a++) mem[a] = 32'(a);
        build_exp(11'h010, 4);
        run_burst(11'h010, 12'd4, 0, 40);
        checks++;
        if (obs_q != exp_q) begin
            errors++;
            $display("FAIL basic_data: got %0d words (first %h) required 4 words 10..13", obs_q.size(),
                     (obs_q.size() > 0) ? obs_q[0] : 32'hx);
        end
        checks++;
        if (hs_cyc_q.size() != 4 || hs_cyc_q[3] - hs_cyc_q[0] != 3) begin
            errors++;
            $display("FAIL basic_throughput: %0d handshakes, not on 4 consecutive cycles", hs_cyc_q.size());
        end
        checks++;
        if (hs_cyc_q.size() == 0 || done_cyc != hs_cyc_q[hs_cyc_q.size()-1] + 1) begin
            errors++;
            $display("FAIL basic_done_timing: done at cycle %0d, required one after last handshake", done_cyc);
        end
        checks++;
        if (post_done !== 1'b0 || post_busy !== 1'b0 || busy_err != 0) begin
            errors++;
            $display("FAIL basic_pulse: post done=%b busy=%b busy_err=%0d required 0/0/0", post_done, post_busy, busy_err);
        end
    endtask

    task automatic test_wrap;
        for (int a = 0; a < 2048; a++) mem[a] = $urandom;
        build_exp(11'h7FE, 4);
        run_burst(11'h7FE, 12'd4, 0, 40);
        checks++;
        if (addr_q != exp_a) begin
            errors++;
            $display("FAIL wrap_addr: %0d addresses issued (first %h) required 7fe,7ff,000,001", addr_q.size(),
                     (addr_q.size() > 0) ? addr_q[0] : 11'hx);
        end
        checks++;
        if (obs_q != exp_q) begin
            errors++;
            $display("FAIL wrap_data: got %0d words, order/value differs from model", obs_q.size());
        end
    endtask

    task automatic test_stall;
        logic [10:0] b;
        b = 11'($urandom);
        build_exp(b, 8);
        run_burst(b, 12'd8, 1, 100);
        checks++;
        if (obs_q != exp_q) begin
            errors++;
            $display("FAIL stall_data: got %0d words, required 8 in address order", obs_q.size());
        end
        checks++;
        if (stable_err != 0) begin
            errors++;
            $display("FAIL stall_stable: out_data changed %0d times during stall, required 0", stable_err);
        end
        checks++;
        if (addr_q.size() != 8 || done_cyc < 0) begin
            errors++;
            $display("FAIL stall_issue: %0d reads issued done_cyc=%0d required 8 reads and done", addr_q.size(), done_cyc);
        end
    endtask

    task automatic test_len0;
        run_burst(11'h123, 12'd0, 0, 10);
        checks++;
        if (done_cyc != 0) begin
            errors++;
            $display("FAIL len0_done: done at cycle %0d required 0", done_cyc);
        end
        checks++;
        if (addr_q.size() != 0 || obs_q.size() != 0 || post_done !== 1'b0) begin
            errors++;
            $display("FAIL len0_quiet: reads=%0d words=%0d post_done=%b required 0/0/0", addr_q.size(), obs_q.size(), post_done);
        end
    endtask

    task automatic test_reset_midburst;
        int hs;
        int done_hits;
        logic [10:0] b;
        hs = 0;
        done_hits = 0;
        b = 11'($urandom);
        @(posedge clk); #1;
        start = 1'b1; base = b; len = 12'd6;
        @(posedge clk); #1;
        start = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 50 && hs < 3; c++) begin
            #1;
            if (out_valid) hs++;
            @(posedge clk); #1;
        end
        checks++;
        if (hs != 3) begin
            errors++;
            $display("FAIL mid_progress: %0d words before reset required 3", hs);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, sram_cen, busy, done, sram_wen} !== 5'b01001 || out_data !== 32'h0) begin
            errors++;
            $display("FAIL mid_reset_outs: valid/cen/busy/done/wen=%b data=%h required 01001/0",
                     {out_valid, sram_cen, busy, done, sram_wen}, out_data);
        end
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            if (done) done_hits++;
        end
        reset_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            if (done) done_hits++;
        end
        checks++;
        if (done_hits != 0) begin
            errors++;
            $display("FAIL mid_no_done: done seen %0d times after reset required 0", done_hits);
        end
        b = 11'($urandom);
        build_exp(b, 2);
        run_burst(b, 12'd2, 0, 30);
        checks++;
        if (obs_q != exp_q || done_cyc < 0) begin
            errors++;
            $display("FAIL mid_restart: got %0d words done_cyc=%0d required 2 model words and done", obs_q.size(), done_cyc);
        end
    endtask

    task automatic test_random;
        for (int k = 0; k < 12; k++) begin
            logic [10:0] b;
            int l;
            b = 11'($urandom);
            l = (k == 11) ? 2048 : int'($urandom_range(1, 40));
            build_exp(b, l);
            run_burst(b, 12'(l), (k % 2 == 0) ? 2 : 0, 4 * l + 40);
            checks++;
            if (obs_q != exp_q || addr_q != exp_a || done_cyc < 0) begin
                errors++;
                $display("FAIL random_burst%0d: base=%h len=%0d words=%0d reads=%0d done_cyc=%0d",
                         k, b, l, obs_q.size(), addr_q.size(), done_cyc);
            end
            checks++;
            if (stable_err != 0 || busy_err != 0) begin
                errors++;
                $display("FAIL random_hold%0d: stable_err=%0d busy_err=%0d required 0/0", k, stable_err, busy_err);
            end
`ifdef SRAM_RD_CHKSUM_EN
            checks++;
            if (chk_at_done !== exp_x) begin
                errors++;
                $display("FAIL random_chksum%0d: got %h required %h", k, chk_at_done, exp_x);
            end
`endif
        end
    endtask

    task automatic test_chksum;
`ifdef SRAM_RD_CHKSUM_EN
        mem[11'h100] = 32'hA5A5A5A5;
        mem[11'h101] = 32'h0F0F0F0F;
        run_burst(11'h100, 12'd2, 1, 30);
        checks++;
        if (chk_at_done !== 32'hAAAAAAAA) begin
            errors++;
            $display("FAIL chksum: got %h required aaaaaaaa", chk_at_done);
        end
`endif
    endtask

    initial begin
        for (int a = 0; a < 2048; a++) mem[a] = '0;
        test_reset();
        test_basic();
        test_wrap();
        test_stall();
        test_len0();
        test_reset_midburst();
        test_random();
        test_chksum();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
